// File: rtl/bp_pkg.sv
// Shared types and memory-map helpers for the back-propagation stream feeder.
package bp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        WAIT_L2,
        WEIGHT_L2,
        WAIT_L1,
        WEIGHT_L1,
        DONE
    } bp_state_t;

    localparam logic [1:0] LAYER_H2 = 2'b10;
    localparam logic [1:0] LAYER_H1 = 2'b01;

    // Output-layer weight matrix starts right after the stored activations.
    function automatic int W_OUT_BASE(input int n_out, input int n_h2, input int n_h1);
        return n_out + n_h2 + n_h1;
    endfunction

    // Each output row carries H2 weights plus one bias word.
    function automatic int W_H2_BASE(input int n_out, input int n_h2, input int n_h1);
        return W_OUT_BASE(n_out, n_h2, n_h1) + n_out * (n_h2 + 1);
    endfunction

endpackage

// File: rtl/bp_transpose_addr_gen.sv
// Transposed matrix walker: addr = base + k*stride + j, j outer, k inner,
// using a row-offset accumulator instead of a multiplier. Reloaded per phase.
module bp_transpose_addr_gen #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] outer_count,
    input  logic [ADDR_WIDTH-1:0] inner_count,
    input  logic [ADDR_WIDTH-1:0] stride,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  busy
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] outer_max_q;
    logic [ADDR_WIDTH-1:0] inner_max_q;
    logic [ADDR_WIDTH-1:0] outer_idx;
    logic [ADDR_WIDTH-1:0] inner_idx;
    logic [ADDR_WIDTH-1:0] row_off;
    logic                  busy_q;
    logic                  inner_end;
    logic                  outer_end;

    assign inner_end = (inner_idx == inner_max_q);
    assign outer_end = (outer_idx == outer_max_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q      <= '0;
            stride_q    <= '0;
            outer_max_q <= '0;
            inner_max_q <= '0;
            outer_idx   <= '0;
            inner_idx   <= '0;
            row_off     <= '0;
            busy_q      <= 1'b0;
        end else if (load) begin
            base_q      <= base;
            stride_q    <= stride;
            outer_max_q <= outer_count - ADDR_WIDTH'(1);
            inner_max_q <= inner_count - ADDR_WIDTH'(1);
            outer_idx   <= '0;
            inner_idx   <= '0;
            row_off     <= '0;
            busy_q      <= 1'b1;
        end else if (busy_q) begin
            if (inner_end) begin
                inner_idx <= '0;
                row_off   <= '0;
                if (outer_end) begin
                    outer_idx <= '0;
                    busy_q    <= 1'b0;
                end else begin
                    outer_idx <= outer_idx + ADDR_WIDTH'(1);
                end
            end else begin
                inner_idx <= inner_idx + ADDR_WIDTH'(1);
                row_off   <= row_off + stride_q;
            end
        end
    end

    assign addr = base_q + row_off + outer_idx;
    assign last = busy_q && inner_end && outer_end;
    assign busy = busy_q;

endmodule

// File: rtl/bp_stream_feeder.sv
// Streams stored forward-pass data backwards, then the output and hidden-2
// weight matrices transposed (bias columns skipped), into back_propagation.
module bp_stream_feeder
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int ADDR_WIDTH                    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic [DATA_WIDTH-1:0]  i_mem_data,
    output logic [LAYER_WIDTH-1:0] o_exp_addr,
    input  logic [DATA_WIDTH-1:0]  i_exp_data,
    output logic                   o_data_valid,
    output logic [DATA_WIDTH-1:0]  o_data_node,
    output logic [DATA_WIDTH-1:0]  o_data_expected,
    input  logic [LAYER_WIDTH-1:0] i_current_layer,
    input  logic                   i_weight_request,
    output logic                   o_weight_valid,
    output logic [DATA_WIDTH-1:0]  o_weight,
    output logic                   o_busy,
    output logic                   o_done,
    output bp_state_t              o_state
);

    localparam int N_OUT   = NUMBER_OF_OUTPUT_NODE;
    localparam int N_H2    = NUMBER_OF_HIDDEN_NODE_LAYER_2;
    localparam int N_H1    = NUMBER_OF_HIDDEN_NODE_LAYER_1;
    localparam int N_NODES = N_OUT + N_H2 + N_H1;

    localparam logic [ADDR_WIDTH-1:0] NODE_LAST = ADDR_WIDTH'(N_NODES - 1);
    localparam logic [ADDR_WIDTH-1:0] OUT_A     = ADDR_WIDTH'(N_OUT);
    localparam logic [ADDR_WIDTH-1:0] H2_A      = ADDR_WIDTH'(N_H2);
    localparam logic [ADDR_WIDTH-1:0] H1_A      = ADDR_WIDTH'(N_H1);
    localparam logic [ADDR_WIDTH-1:0] W_OUT_A   = ADDR_WIDTH'(W_OUT_BASE(N_OUT, N_H2, N_H1));
    localparam logic [ADDR_WIDTH-1:0] W_H2_A    = ADDR_WIDTH'(W_H2_BASE(N_OUT, N_H2, N_H1));

    // Valid/ready: there is no ready. Every valid beat is consumed in the cycle
    // it is shown; data/weight words hold their last value while valid is low.

    bp_state_t             state;
    bp_state_t             state_d;
    logic [ADDR_WIDTH-1:0] node_cnt;
    logic                  gen_load;
    logic [ADDR_WIDTH-1:0] gen_base;
    logic [ADDR_WIDTH-1:0] gen_outer;
    logic [ADDR_WIDTH-1:0] gen_inner;
    logic [ADDR_WIDTH-1:0] gen_stride;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;
    logic                  gen_busy;
    logic                  issue_data;
    logic                  issue_out;
    logic                  issue_weight;
    logic                  data_valid_q;
    logic                  data_out_q;
    logic                  weight_valid_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] node_hold;
    logic [DATA_WIDTH-1:0] exp_hold;
    logic [DATA_WIDTH-1:0] weight_hold;
    logic [DATA_WIDTH-1:0] exp_beat;

    bp_transpose_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (gen_load),
        .base        (gen_base),
        .outer_count (gen_outer),
        .inner_count (gen_inner),
        .stride      (gen_stride),
        .addr        (gen_addr),
        .last        (gen_last),
        .busy        (gen_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            node_cnt <= '0;
        end else begin
            state    <= state_d;
            node_cnt <= (state == DATA && node_cnt != NODE_LAST) ? node_cnt + ADDR_WIDTH'(1) : '0;
        end
    end

    always_comb begin
        state_d    = state;
        gen_load   = 1'b0;
        gen_base   = W_OUT_A;
        gen_outer  = H2_A;
        gen_inner  = OUT_A;
        gen_stride = H2_A + ADDR_WIDTH'(1);
        case (state)
            IDLE:      if (i_start) state_d = DATA;
            DATA:      if (node_cnt == NODE_LAST) state_d = WAIT_L2;
            WAIT_L2: begin
                if (i_weight_request && i_current_layer == LAYER_WIDTH'(LAYER_H2)) begin
                    state_d  = WEIGHT_L2;
                    gen_load = 1'b1;
                end
            end
            WEIGHT_L2: if (gen_last) state_d = WAIT_L1;
            WAIT_L1: begin
                if (i_weight_request && i_current_layer == LAYER_WIDTH'(LAYER_H1)) begin
                    state_d    = WEIGHT_L1;
                    gen_load   = 1'b1;
                    gen_base   = W_H2_A;
                    gen_outer  = H1_A;
                    gen_inner  = H2_A;
                    gen_stride = H1_A + ADDR_WIDTH'(1);
                end
            end
            WEIGHT_L1: if (gen_last) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    assign issue_data   = (state == DATA);
    assign issue_out    = issue_data && (node_cnt < OUT_A);
    assign issue_weight = (state == WEIGHT_L2 || state == WEIGHT_L1) && gen_busy;

    always_comb begin
        o_mem_addr = '0;
        if (issue_data) o_mem_addr = node_cnt;
        else if (issue_weight) o_mem_addr = gen_addr;
    end

    assign o_exp_addr = issue_out ? node_cnt[LAYER_WIDTH-1:0] : '0;

    // RAM data lands one cycle after the address; the flags follow it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_valid_q   <= 1'b0;
            data_out_q     <= 1'b0;
            weight_valid_q <= 1'b0;
            done_q         <= 1'b0;
            node_hold      <= '0;
            exp_hold       <= '0;
            weight_hold    <= '0;
        end else begin
            data_valid_q   <= issue_data;
            data_out_q     <= issue_out;
            weight_valid_q <= issue_weight;
            done_q         <= (state == DONE);
            if (data_valid_q) begin
                node_hold <= i_mem_data;
                exp_hold  <= exp_beat;
            end
            if (weight_valid_q) weight_hold <= i_mem_data;
        end
    end

    assign exp_beat        = data_out_q ? i_exp_data : '0;
    assign o_data_valid    = data_valid_q;
    assign o_data_node     = data_valid_q ? i_mem_data : node_hold;
    assign o_data_expected = data_valid_q ? exp_beat : exp_hold;
    assign o_weight_valid  = weight_valid_q;
    assign o_weight        = weight_valid_q ? i_mem_data : weight_hold;
    assign o_busy          = (state != IDLE);
    assign o_done          = done_q;
    assign o_state         = state;

endmodule

// File: tb/tb_bp_stream_feeder.sv
// Directed bench for bp_stream_feeder: RAM model, spec-level expected queues,
// per-cycle compare process and hand-computed literal pins.
module tb_bp_stream_feeder;
    import bp_pkg::*;

    localparam int N_OUT   = 3;
    localparam int N_H2    = 32;
    localparam int N_H1    = 32;
    localparam int N_NODES = N_OUT + N_H2 + N_H1;
    localparam int W_OUT   = N_NODES;
    localparam int W_H2    = W_OUT + N_OUT * (N_H2 + 1);

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [10:0] o_mem_addr;
    logic [31:0] i_mem_data;
    logic [1:0]  o_exp_addr;
    logic [31:0] i_exp_data;
    logic        o_data_valid;
    logic [31:0] o_data_node;
    logic [31:0] o_data_expected;
    logic [1:0]  i_current_layer;
    logic        i_weight_request;
    logic        o_weight_valid;
    logic [31:0] o_weight;
    logic        o_busy;
    logic        o_done;
    bp_state_t   state_dbg;

    logic [31:0] mem [2048];
    logic [31:0] exp_mem [4];

    int checks = 0;
    int failures = 0;
    int done_count = 0;
    bit saw_bias = 1'b0;

    logic [31:0] exp_node_q[$];
    logic [31:0] exp_expd_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] got_w[$];

    bp_stream_feeder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .o_mem_addr       (o_mem_addr),
        .i_mem_data       (i_mem_data),
        .o_exp_addr       (o_exp_addr),
        .i_exp_data       (i_exp_data),
        .o_data_valid     (o_data_valid),
        .o_data_node      (o_data_node),
        .o_data_expected  (o_data_expected),
        .i_current_layer  (i_current_layer),
        .i_weight_request (i_weight_request),
        .o_weight_valid   (o_weight_valid),
        .o_weight         (o_weight),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_state          (state_dbg)
    );

    // clock / reset / RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 32'(a);
        for (int k = 0; k < 4; k++) exp_mem[k] = 32'h100 + 32'(k);
    end

    always @(posedge clk) begin
        i_mem_data <= mem[o_mem_addr];
        i_exp_data <= exp_mem[o_exp_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    // scoreboard: every valid beat must match the head of its expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_data_valid) begin
                check("data_beat_in_model", 32'(exp_node_q.size() > 0), 32'd1);
                if (exp_node_q.size() > 0) begin
                    check("data_node", o_data_node, exp_node_q.pop_front());
                    check("data_expected", o_data_expected, exp_expd_q.pop_front());
                end
            end
            if (o_weight_valid) begin
                if (o_weight == 32'd99 || o_weight == 32'd132 || o_weight == 32'd165) saw_bias = 1'b1;
                check("weight_beat_in_model", 32'(exp_w_q.size() > 0), 32'd1);
                if (exp_w_q.size() > 0) check("weight", o_weight, exp_w_q.pop_front());
            end
            if (o_done) done_count++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_data_model();
        for (int a = 0; a < N_NODES; a++) begin
            exp_node_q.push_back(32'(a));
            exp_expd_q.push_back((a < N_OUT) ? 32'h100 + 32'(a) : 32'h0);
        end
    endtask

    task automatic push_weight_model(input int base, input int n_outer, input int n_inner);
        for (int j = 0; j < n_outer; j++)
            for (int k = 0; k < n_inner; k++)
                exp_w_q.push_back(32'(base + k * (n_outer + 1) + j));
    endtask

    task automatic run_data(input bit side);
        push_data_model();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            if (side) begin
                i_start          = (c == 10);
                i_weight_request = (c == 20 || c == 67);
                i_current_layer  = LAYER_H2;
            end
            @(negedge clk);
            check("data_valid_window", 32'(o_data_valid), 32'(c >= 2 && c <= 68));
            if (c == 1) begin
                check("first_addr", 32'(o_mem_addr), 32'd0);
                check("first_exp_addr", 32'(o_exp_addr), 32'd0);
                check("busy_in_data", 32'(o_busy), 32'd1);
            end
            if (c == 2) begin
                check("beat0_node", o_data_node, 32'd0);
                check("beat0_exp", o_data_expected, 32'h100);
                check("exp_addr_n1", 32'(o_exp_addr), 32'd1);
            end
            if (c == 3) check("beat1_exp", o_data_expected, 32'h101);
            if (c == 4) check("beat2_exp", o_data_expected, 32'h102);
            if (c == 5) begin
                check("beat3_node", o_data_node, 32'd3);
                check("beat3_exp", o_data_expected, 32'd0);
            end
            if (c == 68) check("beat66_node", o_data_node, 32'd66);
            if (c == 69) begin
                check("data_hold_node", o_data_node, 32'd66);
                check("data_hold_exp", o_data_expected, 32'd0);
                check("state_wait_l2", 32'(state_dbg), 32'(WAIT_L2));
            end
            tick();
        end
        i_start          = 1'b0;
        i_weight_request = 1'b0;
        check("data_model_drained", 32'(exp_node_q.size()), 32'd0);
    endtask

    task automatic req(input logic [1:0] layer);
        i_current_layer  = layer;
        i_weight_request = 1'b1;
        tick();
        i_weight_request = 1'b0;
    endtask

    task automatic stream_w(input int nbeats, input int cut);
        got_w.delete();
        @(negedge clk);
        check("weight_latency", 32'(o_weight_valid), 32'd0);
        tick();
        for (int b = 0; b < nbeats; b++) begin
            i_weight_request = (b == 10 || b == 11);
            @(negedge clk);
            check("weight_contiguous", 32'(o_weight_valid), 32'd1);
            got_w.push_back(o_weight);
            if (b == cut) begin
                #1;
                rst_n            = 1'b0;
                i_weight_request = 1'b0;
                exp_w_q.delete();
                return;
            end
            tick();
        end
        i_weight_request = 1'b0;
        @(negedge clk);
        check("weight_end", 32'(o_weight_valid), 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        i_start          = 1'b0;
        i_weight_request = 1'b0;
        i_current_layer  = 2'b00;
        i_mem_data       = '0;
        i_exp_data       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        check("rst_exp_addr", 32'(o_exp_addr), 32'd0);
        check("rst_data_valid", 32'(o_data_valid), 32'd0);
        check("rst_data_node", o_data_node, 32'd0);
        check("rst_data_expected", o_data_expected, 32'd0);
        check("rst_weight_valid", 32'(o_weight_valid), 32'd0);
        check("rst_weight", o_weight, 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        tick();
        rst_n = 1'b1;

        // a weight request while idle must do nothing
        i_current_layer  = LAYER_H2;
        i_weight_request = 1'b1;
        repeat (4) tick();
        i_weight_request = 1'b0;
        @(negedge clk);
        check("idle_req_busy", 32'(o_busy), 32'd0);
        check("idle_req_state", 32'(state_dbg), 32'(IDLE));
        tick();

        run_data(1'b1);

        // wrong layer code in WAIT_L2 is ignored
        req(LAYER_H1);
        @(negedge clk);
        check("wrong_layer_state", 32'(state_dbg), 32'(WAIT_L2));
        check("wrong_layer_no_beat", 32'(o_weight_valid), 32'd0);
        tick();
        @(negedge clk);
        check("wrong_layer_no_beat2", 32'(o_weight_valid), 32'd0);
        tick();

        push_weight_model(W_OUT, N_H2, N_OUT);
        req(LAYER_H2);
        stream_w(96, -1);
        check("l2_hold", o_weight, 32'd164);
        check("l2_state_wait_l1", 32'(state_dbg), 32'(WAIT_L1));
        check("l2_b0", got_w[0], 32'd67);
        check("l2_b1", got_w[1], 32'd100);
        check("l2_b2", got_w[2], 32'd133);
        check("l2_b3", got_w[3], 32'd68);
        check("l2_b4", got_w[4], 32'd101);
        check("l2_b5", got_w[5], 32'd134);
        check("l2_b95", got_w[95], 32'd164);
        check("l2_model_drained", 32'(exp_w_q.size()), 32'd0);
        tick();

        push_weight_model(W_H2, N_H1, N_H2);
        req(LAYER_H1);
        stream_w(1024, -1);
        check("l1_done_pulse", 32'(o_done), 32'd1);
        check("l1_busy_after", 32'(o_busy), 32'd0);
        check("l1_b0", got_w[0], 32'd166);
        check("l1_b1", got_w[1], 32'd199);
        check("l1_b2", got_w[2], 32'd232);
        check("l1_b1023", got_w[1023], 32'd1220);
        check("l1_model_drained", 32'(exp_w_q.size()), 32'd0);
        check("no_bias_words", 32'(saw_bias), 32'd0);
        tick();
        @(negedge clk);
        check("done_one_cycle", 32'(o_done), 32'd0);
        check("done_count_run1", 32'(done_count), 32'd1);
        tick();

        // second pass, reset during L1 at beat 500
        run_data(1'b0);
        push_weight_model(W_OUT, N_H2, N_OUT);
        req(LAYER_H2);
        stream_w(96, -1);
        tick();
        push_weight_model(W_H2, N_H1, N_H2);
        req(LAYER_H1);
        stream_w(1024, 500);
        check("l1_b500", got_w[500], 32'd841);
        tick();
        @(negedge clk);
        check("abort_weight_valid", 32'(o_weight_valid), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_mem_addr", 32'(o_mem_addr), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_done_after_abort", 32'(done_count), 32'd1);

        // fresh start replays from address 0
        run_data(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
